// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main control FSM: opcodes,
// state encoding and datapath mux/ALU select codes.
package multicycle_main_fsm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles of one access and flags a
// timeout when the count reaches MEM_TIMEOUT without mem_ready.
module multicycle_main_fsm_mem_watchdog #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    input  logic mem_ready,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT > 0) begin : gen_wd
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;

            always_comb begin
                count_next = count_reg;
                if (clear)
                    count_next = '0;
                else if (active && !mem_ready)
                    count_next = count_reg + CNT_W'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    count_reg <= '0;
                else
                    count_reg <= count_next;
            end

            // A ready arriving in the limit cycle wins, so mem_ready gates the flag.
            assign timeout = active && !mem_ready && (count_reg == CNT_W'(MEM_TIMEOUT));
        end else begin : gen_no_wd
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main control FSM (lw, sw, R/I ALU, beq, jal) with memory
// watchdog and retire counter. Define ILLEGAL_TRAP_EN to trap unknown opcodes.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             bus_err,
    output logic             instr_retired,
    output logic [RET_W-1:0] retired_count,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal_instr,
`endif
    output logic [3:0]       state_dbg
);

    state_t state_reg;
    state_t state_next;
    logic   retire;
    logic   mem_state;
    logic   wd_clear;
    logic   timeout;

    assign mem_state = state_reg inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    assign wd_clear  = (state_next != state_reg) &&
                       (state_next inside {S_FETCH, S_MEMREAD, S_MEMWRITE});

    multicycle_main_fsm_mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (mem_state),
        .clear    (wd_clear),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            instr_retired <= 1'b0;
            retired_count <= '0;
        end else begin
            state_reg     <= state_next;
            instr_retired <= retire;
            if (retire)
                retired_count <= retired_count + RET_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_ADD;
        RegWrite   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready)
                    state_next = S_DECODE;
                else if (timeout)
                    state_next = S_ERROR;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready)
                    state_next = S_MEMWB;
                else if (timeout)
                    state_next = S_ERROR;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                // Gated by rst_n so a reset drops the strobe without waiting on the flop.
                MemWrite = rst_n;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_ERROR;
                end
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALUOP_SUB;
                PCWrite    = zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_ERROR, S_TRAP: state_next = state_reg;
            default:         state_next = S_FETCH;
        endcase
    end

    assign ImmSrc    = imm_src_of(opcode);
    assign bus_err   = (state_reg == S_ERROR);
    assign state_dbg = state_reg;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_reg == S_TRAP);
`endif

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
Multi-cycle control unit for the RV32I core subset: lw, sw, R-type, I-type ALU, beq and jal.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Shares one memory port for instructions and data; all memory states wait on a mem_ready handshake.
- Adds a memory-timeout watchdog and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath muxes and enables; the existing alu_decoder consumes ALUOp.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for mem_ready per access; 0 disables the watchdog
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > MEM_TIMEOUT
RET_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register, stable after FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepted/completed the current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = Result
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register and OldPC enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ALUOp  out  2  to alu_decoder: 00 add, 01 sub, 10 funct-decoded
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; combinational from opcode, 00 for unknown
RegWrite  out  1  register file write enable
bus_err  out  1  sticky watchdog error
instr_retired  out  1  one-cycle pulse when an instruction completes
retired_count  out  RET_W  retired instructions, wraps modulo 2^RET_W
state_dbg  out  4  current state encoding

Behaviour:
- Reset (async assert, sync release): state = FETCH, watchdog counter = 0, bus_err = 0, retired_count = 0, instr_retired = 0.
- Datapath outputs are Moore, decoded from state. Exceptions: IRWrite/PCWrite in FETCH and MemWrite in MEMWRITE (see below).
- Unlisted outputs are 0 in each state.

States and transitions:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> FETCH, no retire
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready, then retire -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero, retire -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- ERROR: all enables 0, bus_err=1, terminal until reset.

Retire:
- instr_retired is registered, high the cycle after the retiring state.
- retired_count increments on the same edge.

Watchdog (MEM_TIMEOUT > 0):
- Counter clears on entry to FETCH, MEMREAD or MEMWRITE.
- Increments each cycle in these states while mem_ready=0.
- If mem_ready=0 and the counter equals MEM_TIMEOUT -> ERROR.
- mem_ready=1 in the same cycle as the limit: ready wins, normal transition.

Latency: R/I/jal 4 cycles; beq 3; lw 5; sw 4 (all with zero memory wait).

Reset mid-operation aborts immediately to FETCH. A pending MemWrite is dropped combinationally.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP state.
  - All enables 0; extra output illegal_instr=1, sticky until reset.
  - state_dbg shows TRAP.
- Undefined: unknown opcode returns to FETCH as a NOP. No illegal_instr port.

Decomposition:
Shared package holds:
- opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
- state encoding typedef (4-bit)
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc encodings

One natural sub-module: mem_watchdog (counter + limit compare, outputs timeout).

Test Plan:
- add x3,x1,x2 with mem_ready tied 1 -> states FETCH, DECODE, EXECUTER, ALUWB; RegWrite only in cycle 4; retired_count 0->1.
- lw with mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, then MEMWB with ResultSrc=01, no bus_err.
- beq with zero=1, then with zero=0 -> PCWrite=1 in BEQ cycle for the first, 0 for the second; both retire.
- MEM_TIMEOUT=4, sw with mem_ready never asserted -> MemWrite held 5 cycles, then ERROR, bus_err=1 held.
- mem_ready rising exactly at the limit cycle -> no ERROR.
- Assert rst_n low during MEMWRITE -> MemWrite=0 immediately; state FETCH, retired_count=0. Opcode 1111111 -> FETCH (or TRAP with ILLEGAL_TRAP_EN).
